// File: rtl/reverb_template_nios2_cpu_mult_pipe.sv
// Three-stage DATA_W x DATA_W multiplier with signed/unsigned high-word
// correction, single-enable valid/ready pipe and pass-through tag.
module reverb_template_nios2_cpu_mult_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_W-1:0]     in_src1,
    input  logic [DATA_W-1:0]     in_src2,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [2*DATA_W-1:0]   out_full,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int HALF_W = DATA_W / 2;

    logic adv;

    logic v1_q, v2_q, v3_q;

    logic [DATA_W-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d, corr_d;
    logic [DATA_W-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q, corr_q;
    logic [1:0]        op1_q, op2_q;
    logic [TAG_W-1:0]  tag1_q, tag2_q;
    logic              sa, sb;

    logic [DATA_W:0]   mid;
    logic [DATA_W:0]   lo_sum;
    logic [DATA_W-1:0] lo_d, lo_q, hi_pre_d, hi_pre_q;
    logic              c_d, c_q;

    logic [DATA_W-1:0]   hi;
    logic [2*DATA_W-1:0] full_d;
    logic [DATA_W-1:0]   result_d;

    assign adv       = ~v3_q | out_ready;
    assign in_ready  = adv & ~flush;
    assign out_valid = v3_q;

    // S1: four unsigned half-width partial products plus the signed correction
    always_comb begin
        pp_ll_d = {{HALF_W{1'b0}}, in_src1[HALF_W-1:0]}
                * {{HALF_W{1'b0}}, in_src2[HALF_W-1:0]};
        pp_lh_d = {{HALF_W{1'b0}}, in_src1[HALF_W-1:0]}
                * {{HALF_W{1'b0}}, in_src2[DATA_W-1:HALF_W]};
        pp_hl_d = {{HALF_W{1'b0}}, in_src1[DATA_W-1:HALF_W]}
                * {{HALF_W{1'b0}}, in_src2[HALF_W-1:0]};
        pp_hh_d = {{HALF_W{1'b0}}, in_src1[DATA_W-1:HALF_W]}
                * {{HALF_W{1'b0}}, in_src2[DATA_W-1:HALF_W]};
        sa      = (in_op == 2'b01) || (in_op == 2'b10);
        sb      = (in_op == 2'b01);
        corr_d  = ((sa && in_src1[DATA_W-1]) ? in_src2 : '0)
                + ((sb && in_src2[DATA_W-1]) ? in_src1 : '0);
    end

    // S2: fold the middle products into low word; carry out goes to S3
    always_comb begin
        mid      = {1'b0, pp_lh_q} + {1'b0, pp_hl_q};
        lo_sum   = {1'b0, pp_ll_q}
                 + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
        lo_d     = lo_sum[DATA_W-1:0];
        c_d      = lo_sum[DATA_W];
        hi_pre_d = pp_hh_q + DATA_W'(mid >> HALF_W) - corr_q;
    end

    always_comb begin
        hi       = hi_pre_q + {{(DATA_W-1){1'b0}}, c_q};
        full_d   = {hi, lo_q};
        result_d = (op2_q == 2'b00) ? lo_q : hi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid & in_ready;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pp_ll_q    <= '0;
            pp_lh_q    <= '0;
            pp_hl_q    <= '0;
            pp_hh_q    <= '0;
            corr_q     <= '0;
            op1_q      <= '0;
            tag1_q     <= '0;
            lo_q       <= '0;
            c_q        <= 1'b0;
            hi_pre_q   <= '0;
            op2_q      <= '0;
            tag2_q     <= '0;
            out_full   <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (adv) begin
            pp_ll_q    <= pp_ll_d;
            pp_lh_q    <= pp_lh_d;
            pp_hl_q    <= pp_hl_d;
            pp_hh_q    <= pp_hh_d;
            corr_q     <= corr_d;
            op1_q      <= in_op;
            tag1_q     <= in_tag;
            lo_q       <= lo_d;
            c_q        <= c_d;
            hi_pre_q   <= hi_pre_d;
            op2_q      <= op1_q;
            tag2_q     <= tag1_q;
            out_full   <= full_d;
            out_result <= result_d;
            out_tag    <= tag2_q;
        end
    end

endmodule

// File: tb/tb_reverb_template_nios2_cpu_mult_pipe.sv
// Scoreboard bench: stimulus pushes expected products, a negedge monitor
// pops and compares them, including latency, stall, flush and reset cases.
module tb_reverb_template_nios2_cpu_mult_pipe;

    localparam int DW = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n, flush, in_valid, in_ready;
    logic          out_valid, out_ready;
    logic [1:0]    in_op;
    logic [DW-1:0] in_src1, in_src2, out_result;
    logic [2*DW-1:0] out_full;
    logic [TW-1:0] in_tag, out_tag;

    reverb_template_nios2_cpu_mult_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_full(out_full), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   res;
        logic [2*DW-1:0] full;
        logic [TW-1:0]   tag;
        int              acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: sign/zero-extend operands to 2*DW and multiply
    function automatic logic [2*DW-1:0] model_full(logic [1:0] op,
                                                  logic [DW-1:0] a,
                                                  logic [DW-1:0] b);
        logic [2*DW-1:0] ea, eb;
        ea = (op == 2'b01 || op == 2'b10) ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        eb = (op == 2'b01) ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        return ea * eb;
    endfunction

    always @(negedge clk) begin
        exp_t e, n;
        if (!reset_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = q[0];
                    check("result", 64'(out_result), 64'(e.res));
                    check("full", out_full, e.full);
                    check("tag", 64'(out_tag), 64'(e.tag));
                    if (out_ready) begin
                        if (lat_chk) check("latency", 64'(cyc - e.acc), 64'd3);
                        void'(q.pop_front());
                    end else begin
                        check("in_ready_stall", 64'(in_ready), 64'd0);
                    end
                end
            end
            if (flush) q.delete();
            if (in_valid && in_ready) begin
                n.full = model_full(in_op, in_src1, in_src2);
                n.res  = (in_op == 2'b00) ? n.full[DW-1:0] : n.full[2*DW-1:DW];
                n.tag  = in_tag;
                n.acc  = cyc;
                q.push_back(n);
            end
        end
    end

    task automatic send(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                        logic [TW-1:0] tag);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_src1 = a;
        in_src2 = b;
        in_tag = tag;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);
        idle(2);
    endtask

    function automatic logic [DW-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_op = '0;
        in_src1 = '0;
        in_src2 = '0;
        in_tag = '0;
        #1;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(out_result), 64'd0);
        check("reset_full", out_full, 64'd0);
        check("reset_tag", 64'(out_tag), 64'd0);
        idle(3);
        reset_n = 1'b1;
        idle(1);

        send(2'b00, 32'h0001_0003, 32'h0002_0005, 4'h5);
        drain();

        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1);
        send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);
        send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3);
        drain();

        send(2'b01, 32'h8000_0000, 32'h8000_0000, 4'h6);
        send(2'b01, 32'h8000_0000, 32'h0000_0001, 4'h7);
        send(2'b10, 32'h1234_5678, 32'h8765_4321, 4'h8);
        drain();

        for (int i = 0; i < 8; i++)
            send(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
        drain();

        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
                         4'(9 + i));
            end
            begin
                idle(3);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        send(2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'hA);
        send(2'b01, 32'hCAFE_0001, 32'h8000_0003, 4'hB);
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 2'b00;
        in_src1 = 32'h5;
        in_src2 = 32'h7;
        in_tag = 4'hC;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        idle(6);
        check("flush_queue", 64'(q.size()), 64'd0);

        send(2'b00, 32'h1111, 32'h2222, 4'h1);
        send(2'b01, 32'hF000_0000, 32'h3, 4'h2);
        send(2'b11, 32'hFFFF_0000, 32'h10, 4'h3);
        reset_n = 1'b0;
        #1;
        check("reset_mid_valid", 64'(out_valid), 64'd0);
        check("reset_mid_full", out_full, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        send(2'b10, 32'h8000_0001, 32'hFFFF_FFFF, 4'hE);
        drain();

        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
                         4'($urandom));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        check("final_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
